// File: rtl/acc_stage_if.sv
// Handshake bundle between the partial-product source, the accumulation stage and
// the nonlinear unit. The master drives beats and accepts results. The slave is the stage.
interface acc_stage_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic [WIDTH-1:0] cfg_bias;
  logic [2:0]       cfg_fun_id;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       out_fun_id;
  logic             out_sat;
  logic             out_trunc;
  logic [CNT_W-1:0] out_beats;

  modport master (
    output in_valid, in_data, in_last, cfg_bias, cfg_fun_id, out_ready,
    input  in_ready, out_valid, out_data, out_fun_id, out_sat, out_trunc, out_beats
  );

  modport slave (
    input  in_valid, in_data, in_last, cfg_bias, cfg_fun_id, out_ready,
    output in_ready, out_valid, out_data, out_fun_id, out_sat, out_trunc, out_beats
  );
endinterface

// File: rtl/acc_stage.sv
// Accumulation stage: bias + signed partial products per vector, saturated to WIDTH bits.
// Each result is handed to the nonlinear unit over valid/ready together with its activation select.
module acc_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  acc_stage_if.slave  bus
);
  localparam int ACC_W = WIDTH + CNT_W;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_POS = {{(CNT_W+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_NEG = {{(CNT_W+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                  r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_count;
  logic [2:0]              r_fun_id;
  logic                    r_out_valid;
  logic [WIDTH-1:0]        r_out_data;
  logic                    r_out_sat;
  logic                    r_out_trunc;
  logic [CNT_W-1:0]        r_out_beats;

  logic                    w_beat;
  logic signed [ACC_W-1:0] w_base;
  logic signed [ACC_W-1:0] w_data_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic [CNT_W-1:0]        w_count_nxt;
  logic                    w_force;
  logic                    w_done;
  logic [WIDTH-1:0]        w_sat_data;
  logic                    w_sat;

  assign w_beat = bus.in_valid && !r_out_valid;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_base      = r_acc;
    w_count_nxt = r_count + CNT_W'(1);
    if (r_state == S_IDLE) begin
      w_base      = {{CNT_W{bus.cfg_bias[WIDTH-1]}}, bus.cfg_bias};
      w_count_nxt = CNT_W'(1);
    end
    w_data_ext = {{CNT_W{bus.in_data[WIDTH-1]}}, bus.in_data};
    w_sum      = w_base + w_data_ext;
    w_force    = (w_count_nxt == CNT_MAX);
    w_done     = bus.in_last || w_force;

    w_sat_data = w_sum[WIDTH-1:0];
    w_sat      = 1'b0;
    if (w_sum > SAT_POS) begin
      w_sat_data = OUT_MAX;
      w_sat      = 1'b1;
    end else if (w_sum < SAT_NEG) begin
      w_sat_data = OUT_MIN;
      w_sat      = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_fun_id    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_out_trunc <= 1'b0;
      r_out_beats <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_ACC: begin
          if (w_beat) begin
            r_acc   <= w_sum;
            r_count <= w_count_nxt;
            // The activation select belongs to the vector and is captured only on its first beat.
            if (r_state == S_IDLE) r_fun_id <= bus.cfg_fun_id;
            if (w_done) begin
              r_state     <= S_OUT;
              r_out_valid <= 1'b1;
              r_out_data  <= w_sat_data;
              r_out_sat   <= w_sat;
              r_out_trunc <= w_force;
              r_out_beats <= w_count_nxt;
            end else begin
              r_state <= S_ACC;
            end
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = !r_out_valid;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_fun_id = r_fun_id;
  assign bus.out_sat    = r_out_sat;
  assign bus.out_trunc  = r_out_trunc;
  assign bus.out_beats  = r_out_beats;
endmodule
